// File: rtl/ps2_key_sender.sv
// ps2_key_sender: device-side PS/2 keyboard transmitter.
// It accepts one scan-code request at a time and serializes it as an 11-bit
// device-to-host frame (start, d0..d7, odd parity, stop). A key release goes
// out as the break sequence 0xF0 followed by the code. Each frame is followed
// by an idle gap with both lines high.
module ps2_key_sender #(
  parameter int CLK_DIV  = 4,  // system clocks per PS/2 clock half-period (>= 2)
  parameter int IDLE_GAP = 8   // idle system clocks after every frame (>= 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_release,
  output logic       key_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic [7:0] frames_sent
);

  // Counter widths: the bit-period counter spans 0..2*CLK_DIV-1, the gap
  // counter spans 0..IDLE_GAP-1 (one extra bit keeps IDLE_GAP=1 legal).
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(IDLE_GAP) + 1;

  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IDLE_GAP - 1);
  localparam logic [3:0]    LAST_BIT   = 4'd10;
  localparam logic [7:0]    BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Odd parity: the parity bit makes the total count of ones in d0..d7+p odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Frame image in send order from bit 0 upward: start, data LSB first,
  // parity, stop.
  function automatic logic [10:0] build_frame(input logic [7:0] b);
    return {1'b1, odd_parity(b), b, 1'b0};
  endfunction

  state_t        state_q,     state_d;
  logic [DW-1:0] div_q,       div_d;
  logic [GW-1:0] gap_q,       gap_d;
  logic [3:0]    bit_q,       bit_d;
  logic [10:0]   frame_q,     frame_d;
  logic          pend_q,      pend_d;
  logic [7:0]    pend_code_q, pend_code_d;
  logic          clk_q,       clk_d;
  logic          data_q,      data_d;
  logic [7:0]    frames_q,    frames_d;

  // Helper controls for starting a new frame from IDLE or from the gap.
  logic          start_frame;
  logic [7:0]    start_byte;

  assign key_ready   = (state_q == IDLE);
  assign ps2_clk     = clk_q;
  assign ps2_data    = data_q;
  assign frames_sent = frames_q;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    clk_d       = clk_q;
    data_d      = data_q;
    frames_d    = frames_q;
    start_frame = 1'b0;
    start_byte  = 8'h00;

    case (state_q)
      IDLE: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (key_valid) begin
          // A release sends the break prefix first and keeps the code pending.
          start_frame = 1'b1;
          start_byte  = key_release ? BREAK_CODE : key_code;
          pend_d      = key_release;
          pend_code_d = key_code;
        end
      end

      SEND: begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_HALF) begin
          clk_d = 1'b0;
        end
        if (div_q == DIV_LAST) begin
          // End of one PS/2 clock period: data only moves with the rising
          // clock so it is stable across the host's falling-edge sample.
          div_d = '0;
          clk_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d  = GAP;
            gap_d    = '0;
            data_d   = 1'b1;
            frames_d = frames_q + 8'd1;
          end else begin
            bit_d   = bit_q + 4'd1;
            frame_d = {1'b1, frame_q[10:1]};
            data_d  = frame_q[1];
          end
        end
      end

      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          if (pend_q) begin
            start_frame = 1'b1;
            start_byte  = pend_code_q;
            pend_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        clk_d   = 1'b1;
        data_d  = 1'b1;
      end
    endcase

    // Loading a frame puts the start bit on the line with the clock high,
    // so the first bit period begins on the very next cycle.
    if (start_frame) begin
      state_d = SEND;
      div_d   = '0;
      bit_d   = '0;
      frame_d = build_frame(start_byte);
      clk_d   = 1'b1;
      data_d  = 1'b0;
    end
  end

  // Control state and line registers; reset returns the lines to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      frames_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      frames_q <= frames_d;
    end
  end

  // Frame shifter and pending code: payload only, qualified by the control state.
  always_ff @(posedge clk) begin
    frame_q     <= frame_d;
    pend_code_q <= pend_code_d;
  end

endmodule

// File: tb/tb_ps2_key_sender.sv
// Testbench for ps2_key_sender: expected frames are queued when a request is
// accepted and compared as the host-side monitor decodes frames off the lines.
module tb_ps2_key_sender;

  localparam int D = 4;
  localparam int G = 8;
  localparam int PRESS_READY   = 22 * D + G + 1;
  localparam int RELEASE_READY = 2 * (22 * D + G) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] frames_sent;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  exp_frames;

  ps2_key_sender #(.CLK_DIV(D), .IDLE_GAP(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .key_ready  (key_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line image of one frame, bit 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ~(^b);
    f[10]  = 1'b1;
    return f;
  endfunction

  // Host-side monitor: samples data at every falling PS/2 clock.
  logic        prev_clk = 1'b1;
  logic [3:0]  nbits    = 4'd0;
  logic [10:0] got;
  logic [10:0] want;

  always @(negedge clk) begin
    if (!rst) begin
      nbits    = 4'd0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        got[nbits] = ps2_data;
        nbits      = nbits + 4'd1;
        if (nbits == 4'd11) begin
          nbits = 4'd0;
          check_eq("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check_eq("frame_bits", 32'(got), 32'(want));
          end
        end
      end
      prev_clk = ps2_clk;
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 1000; k++) begin
      if (key_ready) return;
      @(negedge clk);
    end
    check_eq("ready_timeout", 32'(key_ready), 32'd1);
  endtask

  // Issue one request and follow it cycle by cycle until key_ready returns.
  // busy: pulse a competing request at cycle 40; abort_at: reset at that cycle.
  task automatic run_key(input logic [7:0] code, input logic rel, input bit busy, input int abort_at);
    int cyc;
    int exp_ready;
    exp_ready = rel ? RELEASE_READY : PRESS_READY;
    wait_ready();
    @(negedge clk);
    key_valid   = 1'b1;
    key_code    = code;
    key_release = rel;
    @(posedge clk);
    if (rel) exp_q.push_back(frame_of(8'hF0));
    exp_q.push_back(frame_of(code));
    cyc = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      cyc++;
      if (busy && cyc == 40) begin
        key_valid   = 1'b1;
        key_code    = 8'h32;
        key_release = 1'b0;
      end else begin
        key_valid = 1'b0;
      end
      if (cyc == 1)
        check_eq("first_cycle", 32'({ps2_clk, ps2_data, key_ready}), 32'b100);
      if (cyc == D + 1)
        check_eq("first_low_phase", 32'(ps2_clk), 32'd0);
      if (cyc == 22 * D)
        check_eq("frames_before_stop", 32'(frames_sent), 32'(exp_frames));
      if (cyc == 22 * D + 1) begin
        exp_frames = exp_frames + 8'd1;
        check_eq("frames_after_stop", 32'(frames_sent), 32'(exp_frames));
      end
      if (rel && cyc == 22 * D + G + 1)
        check_eq("second_frame_start", 32'({ps2_clk, ps2_data, key_ready}), 32'b100);
      if (rel && cyc == 44 * D + G + 1) begin
        exp_frames = exp_frames + 8'd1;
        check_eq("frames_after_second", 32'(frames_sent), 32'(exp_frames));
      end
      if (cyc == abort_at) begin
        rst = 1'b0;
        #1;
        check_eq("reset_midframe", 32'({ps2_clk, ps2_data, key_ready, frames_sent}), 32'h700);
        exp_frames = 8'd0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (key_ready) break;
    end
    check_eq("ready_cycle", 32'(cyc), 32'(exp_ready));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rc;
    key_valid   = 1'b0;
    key_code    = 8'h00;
    key_release = 1'b0;
    exp_frames  = 8'd0;
    rst         = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("in_reset", 32'({ps2_clk, ps2_data, key_ready, frames_sent}), 32'h700);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle", 32'({ps2_clk, ps2_data, key_ready, frames_sent}), 32'h700);
    end

    run_key(8'h1C, 1'b0, 1'b0, -1);
    run_key(8'h1C, 1'b1, 1'b0, -1);
    run_key(8'h00, 1'b0, 1'b0, -1);
    run_key(8'h1C, 1'b0, 1'b1, -1);
    check_eq("busy_frames", 32'(frames_sent), 32'd5);

    run_key(8'h1C, 1'b0, 1'b0, 30);
    check_eq("after_abort", 32'({ps2_clk, ps2_data, key_ready, frames_sent}), 32'h700);
    run_key(8'h1C, 1'b0, 1'b0, -1);
    check_eq("frames_after_abort", 32'(frames_sent), 32'd1);

    for (int i = 0; i < 4; i++) begin
      rc = 8'($urandom_range(0, 255));
      run_key(rc, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    // Wrap: clean start, then 256 presses bring the counter back to zero.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 8'd0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      run_key(8'(i), 1'b0, 1'b0, -1);
    end
    check_eq("wrap_zero", 32'(frames_sent), 32'd0);

    repeat (4) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
